// File: rtl/shift_reg_piso_gen.sv
// Parametrised PISO shifter: load handshake, shift enable, bit counter and done pulse.
// Optional trailing even-parity bit when SHIFT_PARITY_EN is defined.
module shift_reg_piso_gen #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdi,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  input  logic             shift_en,
  output logic             sdo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SHIFT_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t          state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last_edge;

  assign last_edge = (state == SHIFT) && (cnt == '0) && shift_en;
  assign busy      = (state != IDLE);
  assign q         = shreg;

  always_comb begin
    load_ready = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    load_ready = 1'b1;
`ifdef SHIFT_PARITY_EN
        PARITY:  load_ready = shift_en;
`else
        SHIFT:   load_ready = last_edge;
`endif
        default: load_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    sdo = IDLE_LEVEL;
    case (state)
      SHIFT:   sdo = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
`ifdef SHIFT_PARITY_EN
      PARITY:  sdo = par;
`endif
      default: sdo = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
`ifdef SHIFT_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= d;
            cnt   <= CW'(WIDTH - 1);
            state <= SHIFT;
`ifdef SHIFT_PARITY_EN
            par   <= ^d;
`endif
          end
        end
        SHIFT: begin
          if (shift_en) begin
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], sdi} : {sdi, shreg[WIDTH-1:1]};
            if (cnt == '0) begin
`ifdef SHIFT_PARITY_EN
              state <= PARITY;
`else
              // Final bit: a waiting word overrides the shift so streaming has no gap.
              done <= 1'b1;
              if (load_valid) begin
                shreg <= d;
                cnt   <= CW'(WIDTH - 1);
              end else begin
                state <= IDLE;
              end
`endif
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
`ifdef SHIFT_PARITY_EN
        PARITY: begin
          if (shift_en) begin
            done <= 1'b1;
            if (load_valid) begin
              shreg <= d;
              cnt   <= CW'(WIDTH - 1);
              par   <= ^d;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
